winograd_tile_fetcher: RTL

Upstream feeder for the Winograd F(4x4,3x3) tile engine. Walks a row-major input image in external memory and gathers overlapping 6x6 input tiles with stride 4, zero-padding past the image edge. Presents each tile on a valid/ready handshake; glue drives the tile engine's start from the accepted handshake. Tiles are emitted row-major over the valid-convolution output grid.

---
 rtl/winograd_pkg.sv | 22 ++
 rtl/winograd_tile_addr_gen.sv | 101 ++++++++++
 rtl/winograd_tile_fetcher.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/winograd_pkg.sv
// Shared constants and types for the Winograd F(4x4,3x3) datapath.
// The tile fetcher and the tile engine both import this package.
package winograd_pkg;

    localparam int OUT_N       = 4;
    localparam int KER_N       = 3;
    localparam int TILE_N      = OUT_N + KER_N - 1;
    localparam int TILE_STRIDE = OUT_N;
    localparam int PIX_W       = 32;

    localparam logic [2:0] SLOT_LAST = 3'(TILE_N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_DONE
    } fetch_state_t;

    typedef logic [PIX_W-1:0] tile_t [0:TILE_N-1][0:TILE_N-1];

endpackage

// File: rtl/winograd_tile_addr_gen.sv
// Slot and tile counters for the tile fetcher: tracks (i,j) within a tile and (tr,tc) over
// the output grid, and forms pixel addresses from running row-base registers.
module winograd_tile_addr_gen
    import winograd_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              slot_adv,
    input  logic              tile_adv,
    input  logic [DIM_W-1:0]  img_rows,
    input  logic [DIM_W-1:0]  img_cols,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [2:0]        slot_i,
    output logic [2:0]        slot_j,
    output logic [DIM_W-1:0]  tile_r,
    output logic [DIM_W-1:0]  tile_c,
    output logic              in_range,
    output logic              last_slot,
    output logic              last_tile,
    output logic [ADDR_W-1:0] mem_addr
);

    localparam int EW = DIM_W + 1;

    logic [EW-1:0]     rows_q, cols_q, row0, col0, pix_r, pix_c;
    logic [ADDR_W-1:0] tile_base, row_base, row_step, tile_step;
    logic              last_r, last_c;

    assign pix_r     = row0 + EW'(slot_i);
    assign pix_c     = col0 + EW'(slot_j);
    assign in_range  = (pix_r < rows_q) && (pix_c < cols_q);
    assign last_slot = (slot_i == SLOT_LAST) && (slot_j == SLOT_LAST);

    // A tile row/column is the last one once its 6-wide window reaches the image edge.
    assign last_r    = (row0 + EW'(TILE_N)) >= rows_q;
    assign last_c    = (col0 + EW'(TILE_N)) >= cols_q;
    assign last_tile = last_r && last_c;

    assign row_step  = ADDR_W'(cols_q);
    assign tile_step = row_step << $clog2(TILE_STRIDE);
    assign mem_addr  = row_base + ADDR_W'(pix_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_q    <= '0;
            cols_q    <= '0;
            row0      <= '0;
            col0      <= '0;
            slot_i    <= '0;
            slot_j    <= '0;
            tile_r    <= '0;
            tile_c    <= '0;
            tile_base <= '0;
            row_base  <= '0;
        end else if (init) begin
            rows_q    <= EW'(img_rows);
            cols_q    <= EW'(img_cols);
            row0      <= '0;
            col0      <= '0;
            slot_i    <= '0;
            slot_j    <= '0;
            tile_r    <= '0;
            tile_c    <= '0;
            tile_base <= base_addr;
            row_base  <= base_addr;
        end else begin
            if (slot_adv) begin
                if (slot_j == SLOT_LAST) begin
                    slot_j <= '0;
                    if (slot_i == SLOT_LAST) begin
                        slot_i   <= '0;
                        row_base <= tile_base;
                    end else begin
                        slot_i   <= slot_i + 3'd1;
                        row_base <= row_base + row_step;
                    end
                end else begin
                    slot_j <= slot_j + 3'd1;
                end
            end
            if (tile_adv) begin
                if (last_c) begin
                    tile_c    <= '0;
                    col0      <= '0;
                    tile_r    <= tile_r + 1'b1;
                    row0      <= row0 + EW'(TILE_STRIDE);
                    tile_base <= tile_base + tile_step;
                    row_base  <= tile_base + tile_step;
                end else begin
                    tile_c <= tile_c + 1'b1;
                    col0   <= col0 + EW'(TILE_STRIDE);
                end
            end
        end
    end

endmodule

// File: rtl/winograd_tile_fetcher.sv
// Gathers overlapping 6x6 stride-4 tiles from a row-major image in external memory,
// zero-padding past the image edge, and presents each on a valid/ready handshake.
module winograd_tile_fetcher
    import winograd_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int MAX_DIM = 256,
    parameter int DIM_W   = $clog2(MAX_DIM + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  img_rows,
    input  logic [DIM_W-1:0]  img_cols,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] tile_out [0:TILE_N-1][0:TILE_N-1],
    output logic              tile_valid,
    input  logic              tile_ready,
    output logic [DIM_W-1:0]  tile_row,
    output logic [DIM_W-1:0]  tile_col,
    output logic              busy,
    output logic              done,
    output logic              err
);

    fetch_state_t     state;
    logic             drain, legal, init, slot_adv, accept, tile_adv;
    logic             in_range, last_slot, last_tile;
    logic             cap_valid, cap_in;
    logic [2:0]       slot_i, slot_j, cap_i, cap_j;
    logic [DIM_W-1:0] tr, tc;

    assign legal    = (img_rows >= DIM_W'(KER_N)) && (img_rows <= DIM_W'(MAX_DIM)) &&
                      (img_cols >= DIM_W'(KER_N)) && (img_cols <= DIM_W'(MAX_DIM));
    assign init     = (state == ST_IDLE) && start && legal;
    assign slot_adv = (state == ST_FETCH) && !drain;
    assign accept   = (state == ST_PRESENT) && tile_ready;
    assign tile_adv = accept && !last_tile;
    assign mem_en   = slot_adv && in_range;

    winograd_tile_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .slot_adv  (slot_adv),
        .tile_adv  (tile_adv),
        .img_rows  (img_rows),
        .img_cols  (img_cols),
        .base_addr (base_addr),
        .slot_i    (slot_i),
        .slot_j    (slot_j),
        .tile_r    (tr),
        .tile_c    (tc),
        .in_range  (in_range),
        .last_slot (last_slot),
        .last_tile (last_tile),
        .mem_addr  (mem_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            drain      <= 1'b0;
            tile_valid <= 1'b0;
            tile_row   <= '0;
            tile_col   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (legal) begin
                            state <= ST_FETCH;
                            drain <= 1'b0;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    // The cycle after the last issue waits for that slot's read data to land.
                    if (drain) begin
                        state      <= ST_PRESENT;
                        tile_valid <= 1'b1;
                        tile_row   <= tr;
                        tile_col   <= tc;
                    end else if (last_slot) begin
                        drain <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (tile_ready) begin
                        tile_valid <= 1'b0;
                        if (last_tile) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_FETCH;
                            drain <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid <= 1'b0;
            cap_in    <= 1'b0;
            cap_i     <= '0;
            cap_j     <= '0;
        end else begin
            cap_valid <= slot_adv;
            cap_in    <= in_range;
            cap_i     <= slot_i;
            cap_j     <= slot_j;
        end
    end

    // NOTE: tile storage is reset because its all-zero reset value is visible on tile_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TILE_N; i++) begin
                for (int j = 0; j < TILE_N; j++) begin
                    tile_out[i][j] <= '0;
                end
            end
        end else if (cap_valid) begin
            tile_out[cap_i][cap_j] <= cap_in ? mem_rdata : '0;
        end
    end

endmodule
